// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer: fetch / decode / execute FSM for a simple
// load-store datapath. Control outputs are a Moore decode of the state register;
// a shared wait counter bounds every memory wait and raises a sticky bus error
// when moc never arrives.
module control_sequencer #(
  parameter int unsigned STATE_W    = 7,
  parameter int unsigned TIMEOUT    = 15,
  parameter int unsigned CHECK_COND = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               moc,
  input  logic               cond,
  input  logic [2:0]         iclass,
  output logic               rf_ld,
  output logic               ir_ld,
  output logic               mar_ld,
  output logic               mdr_ld,
  output logic               fr_ld,
  output logic               rw,
  output logic               mov,
  output logic [1:0]         ma,
  output logic [1:0]         mb,
  output logic [1:0]         mc,
  output logic [1:0]         mi,
  output logic               md,
  output logic               mh,
  output logic               bus_err,
  output logic               undef,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    StReset     = 4'd0,
    StFetchAddr = 4'd1,
    StFetchRd   = 4'd2,
    StIrLd      = 4'd3,
    StDecode    = 4'd4,
    StDpReg     = 4'd5,
    StDpImm     = 4'd6,
    StLdAddr    = 4'd7,
    StStAddr    = 4'd8,
    StLdRd      = 4'd9,
    StLdWb      = 4'd10,
    StStData    = 4'd11,
    StStWr      = 4'd12
  } state_e;

  // Last permitted wait cycle: abort when moc is still low on this count.
  localparam logic [7:0] WaitLast = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       undef_q, undef_d;

  logic cond_ok;
  logic in_wait;
  logic timeout_hit;
  logic first_fetch;

  assign cond_ok     = (CHECK_COND != 0) ? cond : 1'b1;
  assign in_wait     = (state_q == StFetchRd) || (state_q == StLdRd) || (state_q == StStWr);
  // moc on the final wait cycle still completes normally.
  assign timeout_hit = in_wait && !moc && (wait_q == WaitLast);
  // Counter is still zero only on the first FETCH_RD cycle (moc=0 bumps it, moc=1 leaves).
  assign first_fetch = (state_q == StFetchRd) && (wait_q == 8'd0);

  // Next-state, wait counter and flag logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StReset:     state_d = StFetchAddr;
      StFetchAddr: state_d = StFetchRd;
      StFetchRd:   if (moc) state_d = StIrLd;
      StIrLd:      state_d = StDecode;
      StDecode: begin
        if (!cond_ok) begin
          state_d = StFetchAddr;
        end else begin
          case (iclass)
            3'd0:    state_d = StDpReg;
            3'd1:    state_d = StDpImm;
            3'd2:    state_d = StLdAddr;
            3'd3:    state_d = StStAddr;
            default: state_d = StFetchAddr;
          endcase
        end
      end
      StDpReg:     state_d = StFetchAddr;
      StDpImm:     state_d = StFetchAddr;
      StLdAddr:    state_d = StLdRd;
      StLdRd:      if (moc) state_d = StLdWb;
      StLdWb:      state_d = StFetchAddr;
      StStAddr:    state_d = StStData;
      StStData:    state_d = StStWr;
      StStWr:      if (moc) state_d = StFetchAddr;
      default:     state_d = StReset;
    endcase
    if (timeout_hit) begin
      state_d = StFetchAddr;
    end

    // Any state change clears the counter, which covers entry into every wait state.
    if (state_d != state_q) begin
      wait_d = 8'd0;
    end else if (in_wait && !moc) begin
      wait_d = wait_q + 8'd1;
    end else begin
      wait_d = wait_q;
    end

    bus_err_d = bus_err_q | timeout_hit;
    // Condition check has priority: a failed condition never flags undef.
    undef_d   = (state_q == StDecode) && cond_ok && iclass[2];
  end

  // State register and registered flags with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StReset;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
      undef_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      undef_q   <= undef_d;
    end
  end

  // Moore decode of control outputs from the current state.
  always_comb begin
    rf_ld  = 1'b0;
    ir_ld  = 1'b0;
    mar_ld = 1'b0;
    mdr_ld = 1'b0;
    fr_ld  = 1'b0;
    rw     = 1'b0;
    mov    = 1'b0;
    ma     = 2'd0;
    mb     = 2'd0;
    mc     = 2'd0;
    mi     = 2'd0;
    md     = 1'b0;
    mh     = 1'b0;
    case (state_q)
      StFetchAddr: begin
        mar_ld = 1'b1;
        ma     = 2'd2;
        md     = 1'b1;
      end
      StFetchRd: begin
        mdr_ld = 1'b1;
        rw     = 1'b1;
        mov    = 1'b1;
        ma     = 2'd2;
        md     = 1'b1;
        // PC increment happens once per fetch, not on every wait cycle.
        if (first_fetch) begin
          rf_ld = 1'b1;
          mc    = 2'd1;
        end
      end
      StIrLd: ir_ld = 1'b1;
      StDpReg: begin
        rf_ld = 1'b1;
        fr_ld = 1'b1;
      end
      StDpImm: begin
        rf_ld = 1'b1;
        fr_ld = 1'b1;
        mb    = 2'd1;
        mh    = 1'b1;
        mi    = 2'd1;
      end
      StLdAddr, StStAddr: begin
        mar_ld = 1'b1;
        mc     = 2'd2;
        md     = 1'b1;
      end
      StLdRd: begin
        mdr_ld = 1'b1;
        rw     = 1'b1;
        mov    = 1'b1;
      end
      StLdWb: begin
        rf_ld = 1'b1;
        mc    = 2'd3;
        md    = 1'b1;
      end
      StStData: begin
        mdr_ld = 1'b1;
        mb     = 2'd2;
      end
      StStWr: mov = 1'b1;
      default: ;
    endcase
  end

  assign bus_err = bus_err_q;
  assign undef   = undef_q;
  assign state   = STATE_W'(state_q);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. An instruction-level model expands
// each instruction (class, condition, memory latencies) into the expected list of
// per-cycle states and outputs; tasks replay that list against the DUT.
module tb_control_sequencer;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst_n, moc, cond;
  logic [2:0] iclass;
  logic       rf_ld, ir_ld, mar_ld, mdr_ld, fr_ld, rw, mov, md, mh, bus_err, undef;
  logic [1:0] ma, mb, mc, mi;
  logic [6:0] state;
  logic [16:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.STATE_W(7), .TIMEOUT(T), .CHECK_COND(1)) dut (
    .clk(clk), .rst_n(rst_n), .moc(moc), .cond(cond), .iclass(iclass),
    .rf_ld(rf_ld), .ir_ld(ir_ld), .mar_ld(mar_ld), .mdr_ld(mdr_ld), .fr_ld(fr_ld),
    .rw(rw), .mov(mov), .ma(ma), .mb(mb), .mc(mc), .mi(mi), .md(md), .mh(mh),
    .bus_err(bus_err), .undef(undef), .state(state)
  );

  always #5 clk = ~clk;

  assign act = {rf_ld, ir_ld, mar_ld, mdr_ld, fr_ld, rw, mov, md, mh, ma, mb, mc, mi};

  typedef struct {
    int st;
    bit first;
    bit m;
    bit undef;
    bit berr;
  } step_t;

  step_t plan[$];
  bit    m_undef = 1'b0;
  bit    m_berr  = 1'b0;

  // Output table straight from the per-state list.
  function automatic logic [16:0] exp_outs(int st, bit first);
    logic rf, ir, mar, mdr, fr, r, mv, d, h;
    logic [1:0] a, b, c, i;
    {rf, ir, mar, mdr, fr, r, mv, d, h} = '0;
    {a, b, c, i} = '0;
    case (st)
      1: begin mar = 1; a = 2; d = 1; end
      2: begin mdr = 1; r = 1; mv = 1; a = 2; d = 1; if (first) begin rf = 1; c = 1; end end
      3: ir = 1;
      5: begin rf = 1; fr = 1; end
      6: begin rf = 1; fr = 1; b = 1; h = 1; i = 1; end
      7, 8: begin mar = 1; c = 2; d = 1; end
      9: begin mdr = 1; r = 1; mv = 1; end
      10: begin rf = 1; c = 3; d = 1; end
      11: begin mdr = 1; b = 2; end
      12: mv = 1;
      default: ;
    endcase
    return {rf, ir, mar, mdr, fr, r, mv, d, h, a, b, c, i};
  endfunction

  function automatic void push(int st, bit first, bit m);
    step_t e;
    e.st = st; e.first = first; e.m = m; e.undef = m_undef; e.berr = m_berr;
    m_undef = 1'b0;
    plan.push_back(e);
  endfunction

  // Memory wait of d cycles with moc low; d >= T means moc never comes.
  function automatic bit plan_wait(int st, int d, bit fetch);
    int lim = (d < int'(T)) ? d : int'(T) - 1;
    for (int k = 0; k <= lim; k++) push(st, fetch && (k == 0), k == d);
    if (d >= int'(T)) begin
      m_berr = 1'b1;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void plan_instr(int ic, bit c, int fd, int mdl);
    push(1, 0, 0);
    if (plan_wait(2, fd, 1)) return;
    push(3, 0, 0);
    push(4, 0, 0);
    if (!c) return;
    if (ic >= 4) begin
      m_undef = 1'b1;
      return;
    end
    case (ic)
      0: push(5, 0, 0);
      1: push(6, 0, 0);
      2: begin
        push(7, 0, 0);
        if (!plan_wait(9, mdl, 0)) push(10, 0, 0);
      end
      default: begin
        push(8, 0, 0);
        push(11, 0, 0);
        void'(plan_wait(12, mdl, 0));
      end
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; moc = 1'b0; cond = 1'b1; iclass = 3'd0;
    @(posedge clk); #1;
    n_tests++;
    if (state !== 7'd0 || act !== 17'd0 || undef !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: state=%0d outs=%h undef=%b bus_err=%b, expected 0/0/0/0",
               state, act, undef, bus_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (state !== 7'd1) begin
      n_fail++;
      $display("FAIL reset_release: state=%0d expected 1", state);
    end
    m_undef = 1'b0; m_berr = 1'b0;
  endtask

  task automatic test_dp_reg();
    plan.delete();
    iclass = 3'd0; cond = 1'b1;
    plan_instr(0, 1, 0, 0);
    foreach (plan[i]) begin
      n_tests++;
      if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
          undef !== plan[i].undef || bus_err !== plan[i].berr) begin
        n_fail++;
        $display("FAIL dp_reg step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b", i,
                 state, act, undef, bus_err, plan[i].st, exp_outs(plan[i].st, plan[i].first),
                 plan[i].undef, plan[i].berr);
      end
      moc = plan[i].m; @(posedge clk); #1;
    end
  endtask

  task automatic test_load();
    plan.delete();
    iclass = 3'd2; cond = 1'b1;
    plan_instr(2, 1, 0, 3);  // moc arrives on the last allowed wait cycle
    foreach (plan[i]) begin
      n_tests++;
      if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
          undef !== plan[i].undef || bus_err !== plan[i].berr) begin
        n_fail++;
        $display("FAIL load step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b", i,
                 state, act, undef, bus_err, plan[i].st, exp_outs(plan[i].st, plan[i].first),
                 plan[i].undef, plan[i].berr);
      end
      moc = plan[i].m; @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    plan.delete();
    iclass = 3'd3; cond = 1'b1;
    plan_instr(3, 1, 2, 1);
    foreach (plan[i]) begin
      n_tests++;
      if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
          undef !== plan[i].undef || bus_err !== plan[i].berr) begin
        n_fail++;
        $display("FAIL store step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b", i,
                 state, act, undef, bus_err, plan[i].st, exp_outs(plan[i].st, plan[i].first),
                 plan[i].undef, plan[i].berr);
      end
      moc = plan[i].m; @(posedge clk); #1;
    end
  endtask

  task automatic test_cond_undef();
    int ics[4] = '{1, 6, 5, 7};
    bit cs[4]  = '{0, 1, 0, 1};
    for (int n = 0; n < 4; n++) begin
      plan.delete();
      iclass = 3'(ics[n]); cond = cs[n];
      plan_instr(ics[n], cs[n], 0, 0);
      foreach (plan[i]) begin
        n_tests++;
        if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
            undef !== plan[i].undef || bus_err !== plan[i].berr) begin
          n_fail++;
          $display("FAIL cond_undef %0d step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b",
                   n, i, state, act, undef, bus_err, plan[i].st,
                   exp_outs(plan[i].st, plan[i].first), plan[i].undef, plan[i].berr);
        end
        moc = plan[i].m; @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_timeout();
    plan.delete();
    iclass = 3'd0; cond = 1'b1;
    plan_instr(0, 1, T, 0);   // fetch never completes
    plan_instr(0, 1, 1, 0);
    plan_instr(2, 1, 0, 2);
    plan_instr(3, 1, 0, 0);
    foreach (plan[i]) begin
      if (plan[i].st == 4) iclass = (i < 12) ? 3'd0 : ((i < 20) ? 3'd2 : 3'd3);
      n_tests++;
      if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
          undef !== plan[i].undef || bus_err !== plan[i].berr) begin
        n_fail++;
        $display("FAIL timeout step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b", i,
                 state, act, undef, bus_err, plan[i].st, exp_outs(plan[i].st, plan[i].first),
                 plan[i].undef, plan[i].berr);
      end
      moc = plan[i].m; @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_wait();
    plan.delete();
    iclass = 3'd3; cond = 1'b1;
    push(1, 0, 0); push(2, 1, 1); push(3, 0, 0); push(4, 0, 0);
    push(8, 0, 0); push(11, 0, 0); push(12, 0, 0); push(12, 0, 0);
    foreach (plan[i]) begin
      n_tests++;
      if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
          undef !== plan[i].undef || bus_err !== plan[i].berr) begin
        n_fail++;
        $display("FAIL mid_wait step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b", i,
                 state, act, undef, bus_err, plan[i].st, exp_outs(plan[i].st, plan[i].first),
                 plan[i].undef, plan[i].berr);
      end
      moc = plan[i].m; @(posedge clk); #1;
    end
    rst_n = 1'b0; moc = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (state !== 7'd0 || act !== 17'd0 || undef !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_reset: state=%0d outs=%h undef=%b bus_err=%b, expected 0/0/0/0",
               state, act, undef, bus_err);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (state !== 7'd1 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_wait_release: state=%0d bus_err=%b, expected 1/0", state, bus_err);
    end
    m_undef = 1'b0; m_berr = 1'b0;
  endtask

  task automatic test_random();
    int ics[$];
    for (int n = 0; n < 30; n++) begin
      int ic  = int'($urandom_range(0, 7));
      bit c   = ($urandom_range(0, 3) != 0);
      int fd  = ($urandom_range(0, 9) == 0) ? int'(T) : int'($urandom_range(0, 3));
      int mdl = ($urandom_range(0, 9) == 0) ? int'(T) : int'($urandom_range(0, 3));
      plan.delete();
      iclass = 3'(ic); cond = c;
      plan_instr(ic, c, fd, mdl);
      foreach (plan[i]) begin
        n_tests++;
        if (state !== 7'(plan[i].st) || act !== exp_outs(plan[i].st, plan[i].first) ||
            undef !== plan[i].undef || bus_err !== plan[i].berr) begin
          n_fail++;
          $display("FAIL random %0d (ic=%0d c=%b fd=%0d md=%0d) step %0d: state=%0d outs=%h u=%b be=%b, expected %0d/%h/%b/%b",
                   n, ic, c, fd, mdl, i, state, act, undef, bus_err, plan[i].st,
                   exp_outs(plan[i].st, plan[i].first), plan[i].undef, plan[i].berr);
        end
        moc = plan[i].m; @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; moc = 1'b0; cond = 1'b1; iclass = 3'd0;
    test_reset();
    test_dp_reg();
    test_load();
    test_store();
    test_cond_undef();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
